// File: rtl/spi_adc_rx.sv
// spi_adc_rx: multi-channel SPI ADC frame receiver.
// Drives nCS/SCLK, deserialises SDIN MSB-first and strobes one word per channel.
module spi_adc_rx #(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              overrun_clr,
    input  logic              nDRDY,
    input  logic              SDIN,
    output logic              SCLK,
    output logic              nCS,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              frame_done,
    output logic              overrun,
    output logic              busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic                r_drdy_s1;
    logic                r_drdy_s2;
    logic [DIV_W-1:0]    r_div;
    logic                r_sclk;
    logic                r_ncs;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_ovr;
    logic                r_last;
    logic [BIT_W-1:0]    r_bit;
    logic [CH_W-1:0]     r_word;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-2:0]   r_shift;
    logic [DATA_W-1:0]   r_data;

    logic                w_wrap;
    logic                w_start;
    logic                w_rise;
    logic                w_fall;
    logic                w_word_end;
    logic [DATA_W-1:0]   w_shift_nx;

    assign w_word_end = w_rise && (r_bit == BIT_MAX);
    assign w_shift_nx = {r_shift, SDIN};

    assign SCLK       = r_sclk;
    assign nCS        = r_ncs;
    assign data_out   = r_data;
    assign data_ch    = r_ch;
    assign data_valid = r_valid;
    assign frame_done = r_done;
    assign overrun    = r_ovr;
    assign busy       = r_busy;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, start detect and SCLK edge decode
    always_comb begin
        w_state_nx = r_state;
        w_wrap     = (r_div == DIV_MAX);
        w_start    = r_drdy_s2 & ~r_drdy_s1;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start && enable) w_state_nx = S_SETUP;
            end
            S_SETUP: begin
                if (w_wrap) w_state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                w_rise = w_wrap & ~r_sclk;
                w_fall = w_wrap & r_sclk;
                if (w_fall && r_last) w_state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (w_wrap) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Two-flop synchroniser for the asynchronous data-ready pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drdy_s1 <= 1'b1;
            r_drdy_s2 <= 1'b1;
        end else begin
            r_drdy_s1 <= nDRDY;
            r_drdy_s2 <= r_drdy_s1;
        end
    end

    // Half-period divider and registered SCLK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_wrap) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_rise) begin
                r_sclk <= 1'b1;
            end else if (w_fall) begin
                r_sclk <= 1'b0;
            end
        end
    end

    // Registered frame-level outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ncs  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ncs  <= (w_state_nx == S_IDLE);
            r_busy <= (w_state_nx != S_IDLE);
            r_done <= (r_state == S_HOLD) && (w_state_nx == S_IDLE);
        end
    end

    // Deserialiser, bit/word counters and word output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_word_end;
            if (r_state == S_IDLE) begin
                r_bit  <= '0;
                r_word <= '0;
                r_last <= 1'b0;
            end else if (w_rise) begin
                r_shift <= w_shift_nx[DATA_W-2:0];
                r_bit   <= w_word_end ? '0 : r_bit + BIT_W'(1);
            end
            if (w_word_end) begin
                r_data <= w_shift_nx;
                r_ch   <= r_word;
                r_word <= r_word + CH_W'(1);
                r_last <= (r_word == CH_LAST);
            end
        end
    end

    // Sticky overrun: a start edge while busy; set beats clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovr <= 1'b0;
        end else if (w_start && r_state != S_IDLE) begin
            r_ovr <= 1'b1;
        end else if (overrun_clr) begin
            r_ovr <= 1'b0;
        end
    end

endmodule

// File: doc/spi_adc_rx.md
Name: spi_adc_rx

Overview:
Parametrised SPI receiver for daisy-chained or multi-channel ADCs: one conversion-ready strobe (nDRDY falling) starts one frame of NUM_CH words of DATA_W bits each.
The block generates nCS and SCLK with a programmable divider and deserialises SDIN MSB-first.
Each word is presented with its channel index and a one-cycle valid strobe.
It sits between the ADC pins and the logger's sample buffer, replacing the fixed 16-bit single-channel receiver.

Parameters:
DATA_W, 16, bits per channel word (2..32)
NUM_CH, 4, channel words per frame (1..16)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
CH_W, max(1,clog2(NUM_CH)), width of channel index (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
enable  in  1  when 1, nDRDY falling edges start frames
overrun_clr  in  1  clears sticky overrun flag
nDRDY  in  1  ADC data-ready, active low, asynchronous
SDIN  in  1  ADC serial data
SCLK  out  1  serial clock to ADC, idle low
nCS  out  1  chip select to ADC, active low, idle high
data_out  out  DATA_W  last received word
data_ch  out  CH_W  channel index of data_out (0 = first word of frame)
data_valid  out  1  one-cycle strobe: data_out/data_ch updated
frame_done  out  1  one-cycle strobe: frame complete, nCS released
overrun  out  1  sticky: nDRDY fell while a frame was in progress
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset values: SCLK=0, nCS=1, data_out=0, data_ch=0, data_valid=0, frame_done=0, overrun=0, busy=0, state=IDLE. Reset is asynchronous and can occur mid-frame; it aborts the frame with no valid strobe.
- nDRDY passes through 2 synchroniser flops. A falling edge is the cycle where stage 2 is 1 and stage 1 is 0. This gives a 1-cycle start pulse.
- State machine:
  - IDLE: SCLK=0, nCS=1.
  - START: (start pulse AND enable AND IDLE) -> CS_SETUP, nCS=0 from the next cycle.
  - CS_SETUP: hold for CLK_DIV cycles -> SHIFT.
  - SHIFT: divider counter counts 0..CLK_DIV-1. On wrap, SCLK toggles.
  - Sampling: on the clk edge where SCLK goes 0->1, SDIN is sampled into the shift register (shift left, LSB in).
  - Bit and word counting: the bit counter increments on each rising SCLK. After bit DATA_W-1 is sampled:
    - data_out <= the full word (MSB = first bit);
    - data_ch <= word index;
    - data_valid=1 for exactly one cycle, in the cycle after the sample.
    - The bit counter clears and the word index increments.
  - End of SHIFT: after word NUM_CH-1, SCLK completes its high half-period and returns low -> CS_HOLD.
  - CS_HOLD: SCLK=0, nCS=0 for CLK_DIV cycles -> IDLE. On entering IDLE, nCS=1 and frame_done=1 for one cycle.
- SCLK is a registered output with no glitches. It has exactly NUM_CH*DATA_W rising edges per frame, and its duty cycle is 50%.
- Duration from nCS falling to nCS rising = CLK_DIV*(2 + 2*NUM_CH*DATA_W) clk cycles.
- Overrun: a start pulse while busy=1 sets overrun. The current frame continues unaffected, and the edge is discarded (no queued frame).
- overrun_clr clears overrun; if a set and a clear occur in the same cycle, set wins.
- Dropping enable mid-frame does not abort the frame. It only blocks new starts.
- A start pulse arriving in the same cycle as frame_done (block back in IDLE) is accepted.
- data_out/data_ch hold their value between strobes.

Test Plan:
- Single frame, DATA_W=16, NUM_CH=2, CLK_DIV=2: ADC model drives 0xA5C3 then 0x1234 on SCLK falling edges.
  - data_valid strobes twice: (ch0, 0xA5C3) then (ch1, 0x1234).
  - nCS is low for 2*(2+64)=132 cycles, with 32 SCLK rising edges.
  - frame_done pulses once.
- Divider sweep, CLK_DIV=1 and CLK_DIV=7, pattern 0xFFFF/0x0001: words are received correctly, and the SCLK high and low phases measure exactly CLK_DIV clk cycles each.
- Overrun: second nDRDY falling edge mid-frame.
  - overrun=1 and stays 1.
  - The frame completes with correct data and only NUM_CH valid strobes.
  - After overrun_clr for one cycle, overrun=0.
- Enable gating: enable=0 with nDRDY edges produces no nCS activity. Dropping enable mid-frame still completes the frame and produces frame_done.
- Reset mid-frame, asserted at bit 5 of word 1: outputs are immediately SCLK=0, nCS=1, data_out=0, with no data_valid. The next nDRDY edge produces a clean full frame.
- Back-to-back: nDRDY falls in the same cycle frame_done asserts. The new frame starts (nCS low again after one cycle high) and overrun stays 0.
